// File: rtl/compass_heading_engine.sv
// Heading engine: calibrated X/Y vector -> 0..359 degrees via restoring divider, atan ROM and octant folding.
// Optional build macro COMPASS_AVG_EN averages 2^AVG_LOG2 calibrated samples per result.
module compass_heading_engine #(
    parameter int W        = 16,
    parameter int FRAC     = 6,
    parameter int AVG_LOG2 = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] y_in,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] cal_x,
    input  logic signed [W-1:0] cal_y,
    input  logic [8:0]          heading_offset,
    output logic [8:0]          heading,
    output logic                zero_err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);

    typedef enum logic [2:0] {IDLE, PREP, DIV, LUT, FIX, DONE} state_t;
    typedef enum logic [1:0] {Q1, Q2, Q3, Q4} quad_t;

    localparam int CW = $clog2(FRAC + 2);

    if (FRAC < 1 || AVG_LOG2 < 1) begin : g_bad_param
        $error("compass_heading_engine: FRAC and AVG_LOG2 must be at least 1");
    end

    state_t              state, state_next;
    logic signed [W:0]   xc_r, yc_r, xc_new, yc_new;
    logic [8:0]          off_r, off_mod;
    logic [W+1:0]        rem;
    logic [W:0]          rem_sub, den, ax, ay, num_n, den_n;
    logic [FRAC:0]       q;
    logic [CW-1:0]       cnt;
    logic                swap, swap_r, zero_vec, zero_r, ge, accept, take;
    quad_t               quad, quad_r;
    logic [6:0]          base;
    logic [8:0]          a, h, h360;
    logic [9:0]          hsum;
    logic [8:0]          heading_r;
    logic                zero_err_r;

    // atan ROM, one entry per ratio step, built from real math at elaboration
    logic [6:0] rom [0:(1<<FRAC)];
    for (genvar k = 0; k <= (1 << FRAC); k++) begin : g_rom
        localparam real ANGLE = $atan(real'(k) / real'(1 << FRAC)) * 180.0 / 3.14159265358979;
        assign rom[k] = 7'($rtoi(ANGLE + 0.5));
    end

    assign accept  = in_valid && (state == IDLE);
    assign xc_new  = {x_in[W-1], x_in} - {cal_x[W-1], cal_x};
    assign yc_new  = {y_in[W-1], y_in} - {cal_y[W-1], cal_y};
    assign off_mod = (heading_offset >= 9'd360) ? heading_offset - 9'd360 : heading_offset;

`ifdef COMPASS_AVG_EN
    localparam int AW = W + 1 + AVG_LOG2;
    logic signed [AW-1:0] acc_x, acc_y, sum_x, sum_y;
    logic [AVG_LOG2-1:0]  n_cnt;
    assign sum_x = acc_x + {{AVG_LOG2{xc_new[W]}}, xc_new};
    assign sum_y = acc_y + {{AVG_LOG2{yc_new[W]}}, yc_new};
    assign take  = accept && (&n_cnt);
`else
    assign take  = accept;
`endif

    // Octant folding inputs derived from the latched calibrated vector
    always_comb begin
        ax       = xc_r[W] ? -xc_r : xc_r;
        ay       = yc_r[W] ? -yc_r : yc_r;
        swap     = ay > ax;
        num_n    = swap ? ax : ay;
        den_n    = swap ? ay : ax;
        zero_vec = (ax == '0) && (ay == '0);
        case ({xc_r[W], yc_r[W]})
            2'b00:   quad = Q1;
            2'b10:   quad = Q2;
            2'b11:   quad = Q3;
            default: quad = Q4;
        endcase
    end

    always_comb begin
        ge      = rem >= {1'b0, den};
        rem_sub = ge ? (W+1)'(rem - {1'b0, den}) : rem[W:0];
    end

    always_comb begin
        a = swap_r ? 9'd90 - 9'(base) : 9'(base);
        case (quad_r)
            Q1:      h = a;
            Q2:      h = 9'd180 - a;
            Q3:      h = 9'd180 + a;
            default: h = 9'd360 - a;
        endcase
        h360 = (h == 9'd360) ? 9'd0 : h;
        hsum = {1'b0, h360} + {1'b0, off_r};
        if (hsum >= 10'd360) hsum = hsum - 10'd360;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (take) state_next = PREP;
            PREP: state_next = zero_vec ? FIX : DIV;
            DIV:  if (cnt == CW'(FRAC)) state_next = LUT;
            LUT:  state_next = FIX;
            FIX:  state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xc_r <= '0; yc_r <= '0; off_r <= '0;
            rem <= '0; den <= '0; q <= '0; cnt <= '0;
            swap_r <= 1'b0; zero_r <= 1'b0; quad_r <= Q1; base <= '0;
            heading_r <= '0; zero_err_r <= 1'b0;
`ifdef COMPASS_AVG_EN
            acc_x <= '0; acc_y <= '0; n_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef COMPASS_AVG_EN
                    if (accept) begin
                        off_r <= off_mod;
                        if (take) begin
                            xc_r  <= sum_x[AW-1:AVG_LOG2];
                            yc_r  <= sum_y[AW-1:AVG_LOG2];
                            acc_x <= '0;
                            acc_y <= '0;
                            n_cnt <= '0;
                        end else begin
                            acc_x <= sum_x;
                            acc_y <= sum_y;
                            n_cnt <= n_cnt + 1'b1;
                        end
                    end
`else
                    if (accept) begin
                        xc_r  <= xc_new;
                        yc_r  <= yc_new;
                        off_r <= off_mod;
                    end
`endif
                end
                PREP: begin
                    rem    <= {1'b0, num_n};
                    den    <= den_n;
                    swap_r <= swap;
                    quad_r <= quad;
                    zero_r <= zero_vec;
                    q      <= '0;
                    cnt    <= '0;
                end
                // One quotient bit per cycle, MSB (weight 2^FRAC) first
                DIV: begin
                    q   <= {q[FRAC-1:0], ge};
                    rem <= {rem_sub, 1'b0};
                    cnt <= cnt + 1'b1;
                end
                LUT: base <= rom[q];
                FIX: begin
                    heading_r  <= zero_r ? 9'd0 : hsum[8:0];
                    zero_err_r <= zero_r;
                end
                DONE: begin
`ifdef COMPASS_AVG_EN
                    if (out_ready) begin
                        acc_x <= '0;
                        acc_y <= '0;
                        n_cnt <= '0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign heading   = heading_r;
    assign zero_err  = zero_err_r;

endmodule

// File: doc/compass_heading_engine.md
Name: compass_heading_engine

Overview:
- Parametrised heading engine for the magnetometer path. Takes one signed X/Y sample pair, applies hard-iron calibration and a mounting offset, and returns an integer heading of 0..359 degrees.
- Replaces the free-running subtract-count ratio with a bounded restoring divider, an atan ROM with 2^FRAC steps, and octant folding.
- Uses valid/ready handshakes on both sides. Sits between the I2C sensor reader and the display/LED logic.

Parameters:
- W, 16: width of the signed sensor input words.
- FRAC, 6: fractional bits of the min/max ratio; the atan ROM has 2^FRAC+1 entries.
- AVG_LOG2, 2: log2 of the averaging window; used only when COMPASS_AVG_EN is defined.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: reset; synchronous, active-high; clears all state.
- x_in, input, W: signed X sample.
- y_in, input, W: signed Y sample.
- in_valid, input, 1: sample present.
- in_ready, output, 1: engine can accept a sample.
- cal_x, input, W: signed hard-iron X offset, sampled on accept.
- cal_y, input, W: signed hard-iron Y offset, sampled on accept.
- heading_offset, input, 9: mounting/declination offset, 0..359, sampled on accept. Values above 359 are treated as (value mod 360).
- heading, output, 9: result in degrees, 0..359.
- zero_err, output, 1: calibrated vector was (0,0).
- out_valid, output, 1: heading and zero_err are valid.
- out_ready, input, 1: consumer takes the result.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Reset values: heading=0, zero_err=0, out_valid=0, busy=0, in_ready=1, state=IDLE. Reset in any state (including mid-DIV) aborts the computation and discards any partial result.
- States: IDLE -> PREP -> DIV -> LUT -> FIX -> DONE -> IDLE.
- in_ready is asserted only in IDLE. A sample is accepted when in_valid&&in_ready.
- PREP (1 cycle):
  - xc=x_in-cal_x and yc=y_in-cal_y, computed as signed W+1 bits, so no overflow.
  - ax=|xc| and ay=|yc|, unsigned W+1 bits.
  - swap = (ay>ax).
  - num = swap?ax:ay, den = swap?ay:ax.
  - Latch the quadrant: xc>=0&&yc>=0 -> Q1; xc<0&&yc>=0 -> Q2; xc<0&&yc<0 -> Q3; xc>=0&&yc<0 -> Q4.
  - If ax==0 and ay==0, skip DIV/LUT and go to FIX with zero flagged.
- DIV (FRAC+1 cycles): restoring division producing q=floor(num*2^FRAC/den), so 0<=q<=2^FRAC (FRAC+1 bits). The cycle count is fixed and does not depend on the data.
- LUT (1 cycle): registered ROM read, base=ROM[q], where ROM[k]=round(atan(k/2^FRAC)*180/pi). For FRAC=6, ROM[0]=0, ROM[5]=4, ROM[64]=45. The ROM is generated at elaboration time, not as a hand-written table.
- FIX (1 cycle):
  - a = swap ? 90-base : base.
  - h = Q1:a, Q2:180-a, Q3:180+a, Q4:360-a; then map 360 to 0.
  - heading = (h + heading_offset) mod 360, computed with a single conditional subtract of 360.
  - For a zero vector: heading=0, zero_err=1, and heading_offset is ignored. Otherwise zero_err=0.
- DONE: out_valid=1. heading and zero_err are held stable until out_ready. On out_valid&&out_ready, go to IDLE, so in_ready=1 on the next cycle.
- Latency: accept edge to out_valid high is FRAC+4 cycles (10 at FRAC=6). Minimum sample period is FRAC+5 cycles when out_ready is held high.
- Boundary cases:
  - x_in = -2^(W-1) with cal = +2^(W-1)-1 gives xc=-(2^W-1), which is representable.
  - A ratio of exactly 1 gives q=2^FRAC.
  - in_valid held high during busy is ignored; no sample is lost because in_ready=0.
  - out_ready asserted outside DONE has no effect.

Optional Feature:
- Macro: COMPASS_AVG_EN.
- Defined:
  - IDLE becomes ACC. in_ready stays high while 2^AVG_LOG2 accepted samples are summed.
  - Each sample is calibrated individually (xc, yc) before it is summed.
  - Accumulators are signed W+1+AVG_LOG2 bits.
  - After the last sample, the averages (acc>>>AVG_LOG2, arithmetic floor) go into PREP. heading_offset is taken from the last accepted sample.
  - The counter and accumulators clear on reset and after each result handshake.
  - Latency from the last accept to out_valid is FRAC+4 cycles.
- Undefined: one sample per result, exactly as described above.

Test Plan:
- Defaults, cal=0, offset=0:
  - (100,0) -> 0.
  - (0,100) -> 90.
  - (-100,0) -> 180.
  - (0,-100) -> 270.
  - Each case: out_valid exactly 10 cycles after accept, zero_err=0.
- (50,50) -> 45 and (-50,-50) -> 225; (30,-60) -> q=32 (swap), ROM[32]=27, a=63, Q4 -> 297.
- (100,-9), heading_offset=10 -> q=5, base=4, Q4 gives 356, plus 10 wraps to 6.
- x_in=cal_x=5, y_in=cal_y=-7, heading_offset=20 -> heading=0, zero_err=1.
- Backpressure: hold out_ready=0 for 20 cycles -> heading stable, in_ready=0, a second in_valid is ignored. Release -> in_ready=1 on the next cycle.
- Reset pulse during DIV cycle 3 -> out_valid stays 0, in_ready=1 on the cycle after reset.
- With COMPASS_AVG_EN and AVG_LOG2=2, samples (101,0), (99,0), (100,4), (100,-4) -> averaged (100,0) -> heading=0 after 4 accepts.
